// File: rtl/sdpb_reader_pkg.sv
// Shared widths and FSM encoding for the SDPB pixel read engine.
package sdpb_reader_pkg;

    localparam int unsigned DEF_ADDR_W = 7;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/sdpb_pixel_reader_pix_fifo2.sv
// Two-entry synchronous FIFO, first-word-fall-through, with occupancy output.
module pix_fifo2 #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem    <= '{default: '0};
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({wr, rd})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign valid = (occ != 2'd0);

    // The issuer's headroom rule must keep us from ever filling past two.
    assert property (@(posedge clk) disable iff (reset) !(wr && !rd && occ == 2'd2))
        else $error("pix_fifo2 overflow");
    assert property (@(posedge clk) disable iff (reset) !(rd && occ == 2'd0))
        else $error("pix_fifo2 underflow");

endmodule

// File: rtl/sdpb_pixel_reader.sv
// Fetches a run of halfwords from the SDPB read port and streams them out valid/ready.
module sdpb_pixel_reader
    import sdpb_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_adb,
    output logic              ram_ceb,
    output logic              ram_oce,
    output logic              ram_resetb,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last
);

    state_t            state, state_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] adb_q;
    logic [CNT_W-1:0]  issue_left;
    logic [CNT_W-1:0]  out_left;
    logic              inflight;
    logic              done_q;
    logic [1:0]        occ;
    logic              pop;
    logic              issue;
    logic              accept;
    logic              zero_run;

    assign pop      = pix_valid & pix_ready;
    assign accept   = (state == IDLE) && start && (count != '0);
    assign zero_run = (state == IDLE) && start && (count == '0);

    // Words buffered plus in flight, less the one leaving now, must stay below two.
    assign issue = (state == RUN) && (issue_left != '0) &&
                   (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (issue && issue_left == CNT_W'(1)) state_next = DRAIN;
            DRAIN:   if (pop && out_left == CNT_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr    <= '0;
            adb_q      <= '0;
            issue_left <= '0;
            out_left   <= '0;
            inflight   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight <= issue;
            done_q   <= zero_run;
            if (accept) begin
                rd_addr    <= base_addr;
                issue_left <= count;
                out_left   <= count;
            end
            if (issue) begin
                rd_addr    <= rd_addr + ADDR_W'(1);
                adb_q      <= rd_addr;
                issue_left <= issue_left - CNT_W'(1);
            end
            if (pop) begin
                out_left <= out_left - CNT_W'(1);
                if (out_left == CNT_W'(1)) done_q <= 1'b1;
            end
        end
    end

    pix_fifo2 #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .wr   (inflight),
        .din  (ram_dout),
        .rd   (pop),
        .dout (pix_data),
        .valid(pix_valid),
        .occ  (occ)
    );

    assign busy       = (state != IDLE);
    assign done       = done_q;
    assign ram_ceb    = issue;
    assign ram_adb    = issue ? rd_addr : adb_q;
    assign ram_oce    = 1'b1;
    assign ram_resetb = reset;
    assign pix_last   = pix_valid && (out_left == CNT_W'(1));

endmodule

// File: tb/tb_sdpb_pixel_reader.sv
// Scoreboard bench for sdpb_pixel_reader against a preloaded RAM model.
module tb_sdpb_pixel_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  base_addr = '0;
    logic [7:0]  count = '0;
    logic        busy, done, ram_ceb, ram_oce, ram_resetb, pix_valid, pix_last;
    logic [6:0]  ram_adb;
    logic [15:0] ram_dout = '0;
    logic [15:0] pix_data;
    logic        pix_ready = 1'b0;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] ram [128];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_pop_edge = -10;
    int          runs_done = 0;
    int          outstanding = 0;
    int          ready_lo = 0;
    bit          zero_mode = 1'b0;
    bit          popped;

    sdpb_pixel_reader #(
        .ADDR_W(7),
        .DATA_W(16),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .ram_adb   (ram_adb),
        .ram_ceb   (ram_ceb),
        .ram_oce   (ram_oce),
        .ram_resetb(ram_resetb),
        .ram_dout  (ram_dout),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial for (int i = 0; i < 128; i++) ram[i] = 16'hA000 + 16'(i);

    always @(posedge clk) begin
        if (ram_resetb) ram_dout <= '0;
        else if (ram_ceb) ram_dout <= ram[ram_adb];
    end

    initial forever begin
        @(posedge clk);
        #1;
        pix_ready = ($urandom_range(0, 99) >= ready_lo);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, tracks read headroom and done timing.
    always @(negedge clk) begin
        if (reset) begin
            outstanding = 0;
        end else begin
            popped = pix_valid && pix_ready;
            if (ram_ceb) check("ceb_headroom", 32'(outstanding - int'(popped) < 2), 1);
            if (popped) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pixel actual=%0h required=none", pix_data);
                end else begin
                    e = sb.pop_front();
                    check("pix_data", pix_data, e.data);
                    check("pix_last", pix_last, e.last);
                    if (e.last) last_pop_edge = cyc + 1;
                end
            end
            if (!zero_mode && (done || cyc == last_pop_edge)) begin
                check("done_timing", done, 32'(cyc == last_pop_edge));
                if (done) runs_done++;
            end
            outstanding += int'(ram_ceb) - int'(popped);
        end
    end

    task automatic run(input int base, input int n, input int lo_pct, input bit glitch, input bit chk_time);
        int c0;
        int lat;
        int t0;
        ready_lo = lo_pct;
        for (int i = 0; i < n; i++) begin
            exp_t x;
            x.data = 16'hA000 + 16'((base + i) % 128);
            x.last = (i == n - 1);
            sb.push_back(x);
        end
        t0 = runs_done;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 7'(base);
        count = 8'(n);
        @(posedge clk);
        #1;
        c0 = cyc;
        start = 1'b0;
        if (chk_time) begin
            for (lat = 1; lat <= 8; lat++) begin
                @(posedge clk);
                #1;
                if (pix_valid) break;
            end
            check("first_valid_latency", lat, 2);
        end
        if (glitch) begin
            repeat (3) @(posedge clk);
            #1;
            start = 1'b1;
            base_addr = 7'd99;
            count = 8'd7;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        for (int k = 0; k < 3000 && runs_done == t0; k++) @(posedge clk);
        check("run_completes", runs_done - t0, 1);
        #1;
        check("busy_after_done", busy, 0);
        if (chk_time) check("run_length", last_pop_edge - c0, n + 2);
        check("scoreboard_empty", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_last", pix_last, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_ram_ceb", ram_ceb, 0);
        check("rst_ram_adb", ram_adb, 0);
        check("rst_ram_oce", ram_oce, 1);
        check("rst_ram_resetb", ram_resetb, 0);

        run(5, 4, 0, 0, 1);
        run(126, 4, 0, 0, 1);

        zero_mode = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 7'd10;
        count = 8'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("zero_no_valid", pix_valid, 0);
            check("zero_no_ceb", ram_ceb, 0);
            check("zero_done_once", done, 0);
        end
        zero_mode = 1'b0;

        run(int'($urandom_range(0, 127)), 128, 30, 0, 0);
        run(int'($urandom_range(0, 127)), 40, 30, 1, 0);
        for (int r = 0; r < 3; r++)
            run(int'($urandom_range(0, 127)), int'($urandom_range(1, 128)), int'($urandom_range(0, 50)), 0, 0);

        // Reset with one word buffered and one read in flight, consumer stalled.
        ready_lo = 100;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 7'd20;
        count = 8'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_reset_valid", pix_valid, 1);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("post_reset_busy", busy, 0);
        check("post_reset_valid", pix_valid, 0);
        check("post_reset_ceb", ram_ceb, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_quiet_valid", pix_valid, 0);
            check("post_reset_quiet_ceb", ram_ceb, 0);
        end
        run(0, 2, 0, 0, 1);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
